// File: rtl/mem_access.sv
// mem_access -- LC-3b memory-stage access controller.
//
// Takes the EX/MEM register contents, runs the data-memory handshake for
// loads, stores, indirect (LDI/STI) and TRAP-vector reads, and stalls the
// front of the pipeline until the access finishes. Load results and the
// pass-through fields go to the MEM/WB register.
//
// Optional feature: define MEM_ACCESS_ALIGN_CHECK_EN to trap odd word
// addresses. A misaligned word access then issues no memory request, finishes
// with zero data, and raises the extra `misalign` output for its DONE cycle.
// Without the macro, bit 0 of a word address is simply cleared.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   exmem_*              EX/MEM register fields (valid, opcode, addr, sr2,
//                        alu, pc, dest)
//   dmem_*               data-memory port (address, read, write, byte_enable,
//                        wdata, rdata, resp)
//   stall                hold IF/ID/EX and EX/MEM this cycle
//   memwb_*              fields presented to the MEM/WB register
//   misalign             (MEM_ACCESS_ALIGN_CHECK_EN only) odd word address
module mem_access (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exmem_valid,
  input  logic [3:0]  exmem_opcode,
  input  logic [15:0] exmem_addr,
  input  logic [15:0] exmem_sr2,
  input  logic [15:0] exmem_alu,
  input  logic [15:0] exmem_pc,
  input  logic [2:0]  exmem_dest,
  output logic [15:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_byte_enable,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall,
  output logic        memwb_valid,
  output logic [15:0] memwb_data,
  output logic [15:0] memwb_alu,
  output logic [15:0] memwb_pc,
  output logic [2:0]  memwb_dest
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  localparam int DATA_W = 16;

  localparam logic [3:0] OP_LDB  = 4'b0010;
  localparam logic [3:0] OP_STB  = 4'b0011;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_TRAP = 4'b1111;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, IND_PTR, DONE} state_t;

  state_t state, state_nxt;

  // Per-instruction context captured in IDLE and used by later states.
  logic [3:0]        op_p1;
  logic              lane_p1;
  logic [DATA_W-1:0] result_p1;

  // Decode of the opcode currently sitting in EX/MEM.
  logic start, word_op, ind_op, store_op, start_mis, ptr_mis;

  // Sign-extend the selected byte of a loaded word.
  function automatic logic [DATA_W-1:0] load_byte(input logic [DATA_W-1:0] w,
                                                  input logic hi);
    logic signed [7:0] b;
    b = hi ? w[15:8] : w[7:0];
    return DATA_W'(b);
  endfunction

  // Value written back for the final access of the latched opcode.
  function automatic logic [DATA_W-1:0] load_result(input logic [3:0] op,
                                                    input logic lane,
                                                    input logic [DATA_W-1:0] w);
    case (op)
      OP_LDB:                 return load_byte(w, lane);
      OP_LDR, OP_LDI, OP_TRAP: return w;
      default:                return '0;
    endcase
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDR) || (op == OP_STR) || (op == OP_LDB) ||
           (op == OP_STB) || (op == OP_LDI) || (op == OP_STI) ||
           (op == OP_TRAP);
  endfunction

  always_comb begin
    start     = exmem_valid && is_mem_op(exmem_opcode);
    word_op   = !((exmem_opcode == OP_LDB) || (exmem_opcode == OP_STB));
    ind_op    = (exmem_opcode == OP_LDI) || (exmem_opcode == OP_STI);
    store_op  = (exmem_opcode == OP_STR) || (exmem_opcode == OP_STB);
    // The first access of LDI/STI is a pointer read, so it is a word access too.
    start_mis = ALIGN_CHK && word_op && exmem_addr[0];
    ptr_mis   = ALIGN_CHK && dmem_rdata[0];
  end

  // ---- state register ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (start_mis)   state_nxt = DONE;
          else if (ind_op) state_nxt = IND_PTR;
          else             state_nxt = ACCESS;
        end
      end
      IND_PTR: begin
        if (dmem_resp) state_nxt = ptr_mis ? DONE : ACCESS;
      end
      ACCESS: begin
        if (dmem_resp) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- outputs to the pipeline ----
  always_comb begin
    stall       = 1'b0;
    memwb_valid = 1'b0;
    memwb_data  = '0;
    unique case (state)
      IDLE: begin
        // Gated by reset so the pipeline is released the instant reset asserts.
        if (start) stall = reset_n;
        else       memwb_valid = exmem_valid;
      end
      IND_PTR, ACCESS: stall = 1'b1;
      DONE: begin
        memwb_valid = 1'b1;
        memwb_data  = result_p1;
      end
      default: ;
    endcase
    memwb_alu  = exmem_alu;
    memwb_pc   = exmem_pc;
    memwb_dest = exmem_dest;
  end

  // ---- memory request registers and latched context ----
  // Request strobes are set on entry to IND_PTR/ACCESS and held, with address
  // and data, until the cycle that sees dmem_resp.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_p1            <= '0;
      lane_p1          <= 1'b0;
      result_p1        <= '0;
      dmem_address     <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= '0;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_p1            <= exmem_opcode;
            lane_p1          <= exmem_addr[0];
            result_p1        <= '0;
            dmem_address     <= word_op ? {exmem_addr[15:1], 1'b0} : exmem_addr;
            dmem_byte_enable <= word_op ? 2'b11 : (exmem_addr[0] ? 2'b10 : 2'b01);
            dmem_wdata       <= (exmem_opcode == OP_STB) ?
                                {exmem_sr2[7:0], exmem_sr2[7:0]} : exmem_sr2;
            dmem_read        <= (state_nxt == IND_PTR) ||
                                ((state_nxt == ACCESS) && !store_op);
            dmem_write       <= (state_nxt == ACCESS) && store_op;
          end
        end
        IND_PTR: begin
          if (dmem_resp) begin
            // Pointer becomes the address of the second (word) access.
            dmem_address <= {dmem_rdata[15:1], 1'b0};
            dmem_read    <= (state_nxt == ACCESS) && (op_p1 == OP_LDI);
            dmem_write   <= (state_nxt == ACCESS) && (op_p1 == OP_STI);
          end
        end
        ACCESS: begin
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            result_p1  <= load_result(op_p1, lane_p1, dmem_rdata);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  // IDLE->DONE and IND_PTR->DONE are only taken on a misaligned word address,
  // and DONE lasts one cycle, so this flag is high exactly for that DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) misalign <= 1'b0;
    else          misalign <= (state_nxt == DONE) &&
                              ((state == IDLE) || (state == IND_PTR));
  end
`endif

endmodule
